text_console: RTL and testbench
===============================

# text_console

Character-stream console engine that sits directly upstream of the VGA text-mode display. It accepts a byte stream (valid/ready), interprets control codes, and writes 16-bit character cells into the text VRAM that the display reads. It handles wrap, scroll-up and clear-screen, and supplies the hardware cursor position and blink phase consumed by the display. Default geometry is the 80x60 8x8-font text mode, with cell address = row*80 + col.

## Interface
- COLS, 80, characters per row (≤128)
- ROWS, 60, rows per screen (≤64)
- BLINK_DIV, 50_000_000, clk cycles per blink toggle
- clk  in  1  system clock (100 MHz)
- rst  in  1  reset, synchronous, active-high
- ch_valid  in  1  byte available
- ch_data  in  8  byte (ASCII / control)
- ch_ready  out  1  engine can accept a byte
- clr_req  in  1  request clear screen (level, sampled in IDLE)
- attr  in  8  colour attribute, written to cell bits [15:8]
- vram_addr  out  13  VRAM cell address
- vram_wdata  out  16  cell = {attr[7:0], 1'b0, code[6:0]}
- vram_we  out  1  VRAM write strobe
- vram_rdata  in  16  VRAM read data, valid 1 cycle after vram_addr
- cursor  out  13  {row[5:0], col[6:0]}, the display's cursor input
- blink  out  1  cursor blink phase
- busy  out  1  high in any state other than IDLE

## Operation
- States: CLEAR, IDLE, PUT, SCROLL_RD, SCROLL_WR, SCROLL_BLANK.
- Reset puts the FSM in CLEAR with idx=0, cursor=0, blink=0, blink counter=0. vram_we is forced to 0 while rst is high.
- CLEAR: one write per cycle to addr idx with data {attr, 8'h20}, idx from 0 to ROWS*COLS-1. Then cursor=0 and go to IDLE.
- IDLE: ch_ready=1 and vram_we=0.
  - If clr_req=1: go to CLEAR. ch_ready is 0 that cycle; clr_req wins over ch_valid.
  - Else if ch_valid: latch ch_data and go to PUT.
- PUT: exactly one cycle. Action depends on the latched byte:
  - 0x20–0x7E: write {attr, 1'b0, byte[6:0]} at row*COLS+col, then advance col. If col was COLS-1, set col=0 and row+1.
  - 0x0D (CR): col=0, no write.
  - 0x0A (LF): col=0, row+1, no write.
  - 0x08 (BS): if col>0, col-1 and write a space at the new position. If col=0, nothing happens.
  - 0x0C (FF): go to CLEAR.
  - Any other byte: consumed, no effect.
  - If row+1 would equal ROWS: row stays ROWS-1 and the FSM goes to SCROLL_RD with idx=0. Otherwise it goes to IDLE.
- Scroll moves every row up by one:
  - For idx 0..(ROWS-1)*COLS-1, SCROLL_RD drives addr=idx+COLS with we=0.
  - SCROLL_WR then drives addr=idx, wdata=vram_rdata, we=1, and increments idx.
  - SCROLL_BLANK writes {attr, 8'h20} to the last row, one cell per cycle.
  - Then go to IDLE with cursor=(ROWS-1, 0).
- Address arithmetic:
  - Computed at 13 bits.
  - For COLS=80 it is (row<<6)+(row<<4)+col, identical to the display's mapping.
  - Highest cell is 4799, with no overflow.
- Blink:
  - Free-running counter 0..BLINK_DIV-1, independent of the FSM.
  - blink toggles on the cycle the counter wraps.

## Timing
- A byte is accepted at edge T (ch_valid & ch_ready). PUT occurs in cycle T+1, and its write is on the bus that cycle. cursor updates at the end of T+1, and ch_ready is 1 again in cycle T+2.
- Peak throughput is one byte per 2 cycles.
- vram_addr, vram_wdata and vram_we are combinational from state, idx and cursor registers, and are stable for the whole cycle.
- CLEAR lasts ROWS*COLS cycles, which is 4800 at defaults.
- Scroll lasts 2*(ROWS-1)*COLS + COLS cycles, which is 9520 at defaults. ch_ready=0 throughout.
- rst asserted mid-scroll or mid-clear aborts immediately and restarts CLEAR from idx 0.
- clr_req asserted outside IDLE is ignored until IDLE. It is not queued.
- The cursor never shows an out-of-range value: col<COLS and row<ROWS at all times.

## Test plan
- **Reset clear:** assert rst for 2 cycles, then release. Expect exactly 4800 writes of {attr, 8'h20} to addrs 0..4799, cursor=0, then ch_ready=1.
- **Put/wrap:** send 'A' (0x41) with attr=8'hF0. Expect a write of 16'hF041 at addr 0 and cursor=13'h0001. Then send 80 chars from col 0. Expect the last at addr 79, then cursor={6'd1, 7'd0}.
- **Control codes:**
  - At (2,5), send BS: expect a write of a space at addr 164 and cursor (2,4).
  - Then CR: cursor (2,0), no write.
  - Then LF: cursor (3,0), no write.
  - At col 0, BS: no write.
- **Scroll:** preload the VRAM model with cell=addr, then send LF at row 59. Expect:
  - addr 0 gets 80 and addr 4719 gets 4799.
  - addrs 4720..4799 get spaces.
  - cursor=(59,0), with busy for 9520 cycles.
- **Clear paths:** send FF, then separately assert clr_req together with ch_valid in IDLE. Expect the full clear in both cases, with the byte not consumed in the clr_req case.
- **Blink/reset abort:** with BLINK_DIV=4, expect blink to toggle every 4 cycles. Assert rst mid-scroll: expect we=0 that cycle, then a fresh clear from addr 0.

Source files
------------

// File: rtl/text_console.sv
`timescale 1ns/1ps
// text_console: byte-stream console engine feeding the text-mode VRAM.
// Accepts bytes over valid/ready, interprets CR/LF/BS/FF, writes character
// cells, wraps and scrolls, and supplies cursor position and blink phase.
module text_console #(
  parameter int COLS      = 80,
  parameter int ROWS      = 60,
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  input  logic        clr_req,
  input  logic [7:0]  attr,
  output logic [12:0] vram_addr,
  output logic [15:0] vram_wdata,
  output logic        vram_we,
  input  logic [15:0] vram_rdata,
  output logic [12:0] cursor,
  output logic        blink,
  output logic        busy
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [12:0]        COLS_W      = 13'(COLS);
  localparam logic [12:0]        LAST_CELL   = 13'(ROWS * COLS - 1);
  localparam logic [12:0]        LAST_SCROLL = 13'((ROWS - 1) * COLS - 1);
  localparam logic [6:0]         LAST_COL    = 7'(COLS - 1);
  localparam logic [5:0]         LAST_ROW    = 6'(ROWS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic [2:0] {
    CLEAR        = 3'd0,
    IDLE         = 3'd1,
    PUT          = 3'd2,
    SCROLL_RD    = 3'd3,
    SCROLL_WR    = 3'd4,
    SCROLL_BLANK = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic [12:0]        idx_r, idx_s;
  logic [5:0]         row_r, row_s;
  logic [6:0]         col_r, col_s;
  logic [7:0]         code_r, code_s;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               blink_r;

  logic [12:0] cell_addr_s;
  logic [15:0] space_cell_s;
  logic        adv_row_s;
  logic        we_s;
  logic        ready_s;
  logic [12:0] addr_s;
  logic [15:0] wdata_s;

  // Linear cell address of the cursor; a constant multiply reduces to shifts/adds.
  assign cell_addr_s  = ({7'd0, row_r} * COLS_W) + {6'd0, col_r};
  assign space_cell_s = {attr, 8'h20};

  assign vram_addr  = addr_s;
  assign vram_wdata = wdata_s;
  assign vram_we    = we_s & ~rst;
  assign ch_ready   = ready_s;
  assign cursor     = {row_r, col_r};
  assign busy       = (state_r != IDLE);
  assign blink      = blink_r;

  // FSM and cursor state registers; reset restarts a full clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CLEAR;
      idx_r   <= 13'd0;
      row_r   <= 6'd0;
      col_r   <= 7'd0;
      code_r  <= 8'd0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      row_r   <= row_s;
      col_r   <= col_s;
      code_r  <= code_s;
    end
  end

  // Next-state, cursor movement and VRAM bus drive for each state.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    row_s     = row_r;
    col_s     = col_r;
    code_s    = code_r;
    addr_s    = 13'd0;
    wdata_s   = 16'd0;
    we_s      = 1'b0;
    ready_s   = 1'b0;
    adv_row_s = 1'b0;

    case (state_r)
      CLEAR: begin
        addr_s  = idx_r;
        wdata_s = space_cell_s;
        we_s    = 1'b1;
        if (idx_r == LAST_CELL) begin
          idx_s   = 13'd0;
          row_s   = 6'd0;
          col_s   = 7'd0;
          state_s = IDLE;
        end else begin
          idx_s = idx_r + 13'd1;
        end
      end

      IDLE: begin
        // A clear request takes priority and holds off the byte stream.
        if (clr_req) begin
          idx_s   = 13'd0;
          state_s = CLEAR;
        end else begin
          ready_s = 1'b1;
          if (ch_valid) begin
            code_s  = ch_data;
            state_s = PUT;
          end else begin
            state_s = IDLE;
          end
        end
      end

      PUT: begin
        state_s = IDLE;
        if ((code_r >= 8'h20) && (code_r <= 8'h7E)) begin
          addr_s  = cell_addr_s;
          wdata_s = {attr, 1'b0, code_r[6:0]};
          we_s    = 1'b1;
          if (col_r == LAST_COL) begin
            col_s     = 7'd0;
            adv_row_s = 1'b1;
          end else begin
            col_s = col_r + 7'd1;
          end
        end else if (code_r == 8'h0D) begin
          col_s = 7'd0;
        end else if (code_r == 8'h0A) begin
          col_s     = 7'd0;
          adv_row_s = 1'b1;
        end else if (code_r == 8'h08) begin
          // Backspace blanks the cell left of the cursor; inert at column 0.
          if (col_r != 7'd0) begin
            col_s   = col_r - 7'd1;
            addr_s  = cell_addr_s - 13'd1;
            wdata_s = space_cell_s;
            we_s    = 1'b1;
          end else begin
            col_s = col_r;
          end
        end else if (code_r == 8'h0C) begin
          idx_s   = 13'd0;
          state_s = CLEAR;
        end else begin
          state_s = IDLE;
        end

        // Moving past the last row pins the cursor there and scrolls instead.
        if (adv_row_s) begin
          if (row_r == LAST_ROW) begin
            idx_s   = 13'd0;
            state_s = SCROLL_RD;
          end else begin
            row_s = row_r + 6'd1;
          end
        end else begin
          row_s = row_r;
        end
      end

      SCROLL_RD: begin
        addr_s  = idx_r + COLS_W;
        state_s = SCROLL_WR;
      end

      SCROLL_WR: begin
        addr_s  = idx_r;
        wdata_s = vram_rdata;
        we_s    = 1'b1;
        idx_s   = idx_r + 13'd1;
        if (idx_r == LAST_SCROLL) begin
          state_s = SCROLL_BLANK;
        end else begin
          state_s = SCROLL_RD;
        end
      end

      SCROLL_BLANK: begin
        addr_s  = idx_r;
        wdata_s = space_cell_s;
        we_s    = 1'b1;
        if (idx_r == LAST_CELL) begin
          idx_s   = 13'd0;
          row_s   = LAST_ROW;
          col_s   = 7'd0;
          state_s = IDLE;
        end else begin
          idx_s = idx_r + 13'd1;
        end
      end

      default: begin
        idx_s   = 13'd0;
        state_s = CLEAR;
      end
    endcase
  end

  // Free-running blink divider, independent of the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_r <= '0;
      blink_r     <= 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= '0;
      blink_r     <= ~blink_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
    end
  end

endmodule

// File: tb/tb_text_console.sv
`timescale 1ns/1ps
// Directed testbench for text_console with a synchronous-read VRAM model.
module tb_text_console;

  logic        clk = 1'b0;
  logic        rst;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic        clr_req;
  logic [7:0]  attr;
  logic [12:0] vram_addr;
  logic [15:0] vram_wdata;
  logic        vram_we;
  logic [15:0] vram_rdata;
  logic [12:0] cursor;
  logic        blink;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:8191];
  logic        preload_go = 1'b0;

  always #5 clk = ~clk;

  text_console #(.COLS(80), .ROWS(60), .BLINK_DIV(4)) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(ch_ready), .clr_req(clr_req), .attr(attr),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
    .vram_rdata(vram_rdata), .cursor(cursor), .blink(blink), .busy(busy)
  );

  // VRAM model: write port plus one-cycle-latency read; preload sets cell=addr.
  always @(posedge clk) begin
    if (preload_go) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 16'(i);
    end else if (vram_we) begin
      mem[vram_addr] <= vram_wdata;
    end
    vram_rdata <= mem[vram_addr];
  end

  typedef struct {
    logic [7:0]  at;
    logic [7:0]  b;
    logic        we;
    logic [12:0] addr;
    logic [15:0] data;
    logic [12:0] cur;
  } vec_t;

  vec_t vecs [19];

  function automatic logic [12:0] cur(input int r, input int c);
    return 13'((r << 7) | c);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Present one byte in IDLE; return what the PUT cycle drove on the VRAM bus.
  task automatic send(input logic [7:0] b, output logic we, output logic [12:0] a,
                      output logic [15:0] d);
    chk("ready_before_send", {31'd0, ch_ready}, 32'd1);
    ch_data  = b;
    ch_valid = 1'b1;
    @(negedge clk);
    ch_valid = 1'b0;
    #1;
    we = vram_we;
    a  = vram_addr;
    d  = vram_wdata;
    @(negedge clk);
    #1;
  endtask

  // Expect a full clear starting this cycle; optionally poke clr_req mid-clear.
  task automatic clear_check(input string name, input bit from_reset, input bit pulse_clr);
    int bad;
    logic [8:0] hist;
    bad  = 0;
    hist = '0;
    for (int i = 0; i < 4800; i++) begin
      if (pulse_clr && i == 100) clr_req = 1'b1;
      if (pulse_clr && i == 103) clr_req = 1'b0;
      if (i < 9) hist[i] = blink;
      if (!(vram_we === 1'b1 && vram_addr === 13'(i) && vram_wdata === {attr, 8'h20})) begin
        if (bad == 0)
          $display("  %s: first bad clear cell %0d we=%b addr=%0d data=%h",
                   name, i, vram_we, vram_addr, vram_wdata);
        bad++;
      end
      @(negedge clk);
      #1;
    end
    chk({name, "_bad_cells"}, 32'(bad), 32'd0);
    if (from_reset) chk({name, "_blink_phase"}, 32'(hist), 32'h0F0);
    chk({name, "_cursor"}, 32'(cursor), 32'd0);
    chk({name, "_ready"}, {31'd0, ch_ready}, 32'd1);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    #1;
    chk({name, "_stays_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #3ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic        we;
    logic [12:0] a;
    logic [15:0] d;
    int bad, cyc, nwr;
    logic [15:0] exp;
    logic [7:0]  b;

    // attr, byte, write?, addr, data, cursor after
    vecs[0]  = '{8'hF0, 8'h41, 1'b1, 13'd0,   16'hF041, cur(0, 1)};
    vecs[1]  = '{8'hF0, 8'h0D, 1'b0, 13'd0,   16'h0000, cur(0, 0)};
    vecs[2]  = '{8'hF0, 8'h0A, 1'b0, 13'd0,   16'h0000, cur(1, 0)};
    vecs[3]  = '{8'hF0, 8'h0A, 1'b0, 13'd0,   16'h0000, cur(2, 0)};
    vecs[4]  = '{8'hF0, 8'h48, 1'b1, 13'd160, 16'hF048, cur(2, 1)};
    vecs[5]  = '{8'hF0, 8'h45, 1'b1, 13'd161, 16'hF045, cur(2, 2)};
    vecs[6]  = '{8'hF0, 8'h4C, 1'b1, 13'd162, 16'hF04C, cur(2, 3)};
    vecs[7]  = '{8'hF0, 8'h4C, 1'b1, 13'd163, 16'hF04C, cur(2, 4)};
    vecs[8]  = '{8'hF0, 8'h4F, 1'b1, 13'd164, 16'hF04F, cur(2, 5)};
    vecs[9]  = '{8'hF0, 8'h08, 1'b1, 13'd164, 16'hF020, cur(2, 4)};
    vecs[10] = '{8'hF0, 8'h0D, 1'b0, 13'd0,   16'h0000, cur(2, 0)};
    vecs[11] = '{8'hF0, 8'h0A, 1'b0, 13'd0,   16'h0000, cur(3, 0)};
    vecs[12] = '{8'hF0, 8'h08, 1'b0, 13'd0,   16'h0000, cur(3, 0)};
    vecs[13] = '{8'hF0, 8'h01, 1'b0, 13'd0,   16'h0000, cur(3, 0)};
    vecs[14] = '{8'hF0, 8'h7F, 1'b0, 13'd0,   16'h0000, cur(3, 0)};
    vecs[15] = '{8'h1F, 8'h7E, 1'b1, 13'd240, 16'h1F7E, cur(3, 1)};
    vecs[16] = '{8'h1F, 8'h20, 1'b1, 13'd241, 16'h1F20, cur(3, 2)};
    vecs[17] = '{8'hA5, 8'hC1, 1'b0, 13'd0,   16'h0000, cur(3, 2)};
    vecs[18] = '{8'hF0, 8'h1F, 1'b0, 13'd0,   16'h0000, cur(3, 2)};

    rst      = 1'b1;
    ch_valid = 1'b0;
    ch_data  = 8'h00;
    clr_req  = 1'b0;
    attr     = 8'hF0;

    // Reset for two cycles; write strobe must stay low while rst is high.
    @(negedge clk);
    #1;
    chk("we_low_in_reset", {31'd0, vram_we}, 32'd0);
    chk("blink_reset", {31'd0, blink}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    clear_check("reset_clear", 1'b1, 1'b0);

    // Table-driven printable and control codes.
    for (int k = 0; k < 19; k++) begin
      attr = vecs[k].at;
      send(vecs[k].b, we, a, d);
      chk($sformatf("vec%0d_we", k), {31'd0, we}, {31'd0, vecs[k].we});
      if (vecs[k].we) begin
        chk($sformatf("vec%0d_addr", k), 32'(a), 32'(vecs[k].addr));
        chk($sformatf("vec%0d_data", k), 32'(d), 32'(vecs[k].data));
      end
      chk($sformatf("vec%0d_cursor", k), 32'(cursor), 32'(vecs[k].cur));
    end
    attr = 8'hF0;

    // Full row of 80 characters from column 0 wraps to the next row.
    send(8'h0D, we, a, d);
    send(8'h0A, we, a, d);
    chk("wrap_start_cursor", 32'(cursor), 32'(cur(4, 0)));
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      b = 8'h30 + 8'(i % 10);
      send(b, we, a, d);
      if (!(we === 1'b1 && a === 13'(320 + i) && d === {8'hF0, 1'b0, b[6:0]})) bad++;
    end
    chk("wrap_row_writes", 32'(bad), 32'd0);
    chk("wrap_last_addr", 32'(a), 32'd399);
    chk("wrap_cursor", 32'(cursor), 32'(cur(5, 0)));

    // Form feed clears; clr_req raised mid-clear must not queue a second clear.
    send(8'h0C, we, a, d);
    chk("ff_no_put_write", {31'd0, we}, 32'd0);
    clear_check("ff_clear", 1'b0, 1'b1);

    // clr_req together with ch_valid in IDLE: clear wins, byte dropped.
    clr_req  = 1'b1;
    ch_valid = 1'b1;
    ch_data  = 8'h41;
    #1;
    chk("clr_req_blocks_ready", {31'd0, ch_ready}, 32'd0);
    @(negedge clk);
    clr_req  = 1'b0;
    ch_valid = 1'b0;
    #1;
    clear_check("clr_req_clear", 1'b0, 1'b0);
    chk("clr_req_byte_dropped", 32'(mem[0]), 32'hF020);

    // Walk down to the last row without scrolling.
    for (int i = 0; i < 59; i++) send(8'h0A, we, a, d);
    chk("last_row_cursor", 32'(cursor), 32'(cur(59, 0)));
    chk("last_row_no_scroll", {31'd0, busy}, 32'd0);

    preload_go = 1'b1;
    @(negedge clk);
    preload_go = 1'b0;
    #1;

    // LF on the last row: scroll every row up and blank the bottom row.
    ch_data  = 8'h0A;
    ch_valid = 1'b1;
    @(negedge clk);
    ch_valid = 1'b0;
    #1;
    chk("scroll_put_no_write", {31'd0, vram_we}, 32'd0);
    @(negedge clk);
    #1;
    cyc = 0;
    nwr = 0;
    bad = 0;
    while (busy === 1'b1 && cyc < 20000) begin
      chk_ready_low: if (ch_ready !== 1'b0) bad++;
      if (vram_we === 1'b1) begin
        exp = (nwr < 4720) ? 16'(nwr + 80) : 16'hF020;
        if (vram_addr !== 13'(nwr) || vram_wdata !== exp) bad++;
        nwr++;
      end
      cyc++;
      @(negedge clk);
      #1;
    end
    chk("scroll_cycles", 32'(cyc), 32'd9520);
    chk("scroll_writes", 32'(nwr), 32'd4800);
    chk("scroll_bad", 32'(bad), 32'd0);
    chk("scroll_cursor", 32'(cursor), 32'(cur(59, 0)));
    chk("scroll_ready", {31'd0, ch_ready}, 32'd1);
    chk("scroll_cell0", 32'(mem[0]), 32'd80);
    chk("scroll_cell4719", 32'(mem[4719]), 32'd4799);
    chk("scroll_cell4720", 32'(mem[4720]), 32'hF020);
    chk("scroll_cell4799", 32'(mem[4799]), 32'hF020);
    chk("scroll_cell4800_untouched", 32'(mem[4800]), 32'd4800);

    // Reset in the middle of a scroll write aborts and restarts the clear.
    ch_data  = 8'h0A;
    ch_valid = 1'b1;
    @(negedge clk);
    ch_valid = 1'b0;
    @(negedge clk);
    repeat (101) @(negedge clk);
    #1;
    chk("abort_in_scroll_wr", {31'd0, vram_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_we_forced_low", {31'd0, vram_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    clear_check("abort_clear", 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
